// File: rtl/modulo_mux_scan_n.sv
// modulo_mux_scan_n
//   Parametrised CHANNELS-way, WIDTH-bit multiplexer with a registered output
//   and a valid/ready handshake. There are two operating modes:
//   - MANUAL: the channel is chosen by sel_in.
//   - SCAN: channels are visited round-robin, with DWELL cycles spent on each.
//   A new sample is captured only when the output slot is free, so a sample
//   that is waiting for the consumer is never overwritten.
//
// Optional feature:
//   MUX_CH_MASK_EN adds a ch_mask input (1 = channel enabled).
//   - SCAN skips masked channels.
//   - A MANUAL select of a masked channel is reported as a select error.
//
// Ports:
//   clk, rst_n      clock (rising edge); asynchronous active-low reset
//   data_in         channel k occupies bits [k*WIDTH +: WIDTH]
//   enable, mode    enable=0 -> idle; mode=0 -> MANUAL, mode=1 -> SCAN
//   sel_in          channel select, used in MANUAL mode only
//   ch_mask         per-channel enable (only with MUX_CH_MASK_EN)
//   out_ready       consumer accepts the sample when out_valid & out_ready
//   out_data        captured sample
//   out_sel         channel index of out_data
//   out_valid       out_data/out_sel hold a sample not yet accepted
//   sel_err         one-cycle pulse after a MANUAL capture with a bad select
module modulo_mux_scan_n #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      enable,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
`ifdef MUX_CH_MASK_EN
  input  logic [CHANNELS-1:0]       ch_mask,
`endif
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  output logic                      sel_err
);

  localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_MANUAL, ST_SCAN} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [DW_W-1:0]     dwell_q, dwell_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_sel_q, out_sel_d;
  logic                out_valid_q, out_valid_d;
  logic                sel_err_q, sel_err_d;

  logic [CHANNELS-1:0] ch_en;
  logic                free;
  logic                sel_ok;
  logic [PTR_W:0]      scan_hit;
  logic [PTR_W:0]      next_hit;

`ifdef MUX_CH_MASK_EN
  assign ch_en = ch_mask;
`else
  assign ch_en = '1;
`endif

  // Select one channel of the packed input bus by integer index.
  function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] d,
                                            input int idx);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (k == idx) r = d[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  // First enabled channel at or after 'start', wrapping around.
  // The MSB of the result is the found flag; the low bits hold the index.
  // The loop runs backwards, so the candidate closest to 'start' is the one
  // written last and therefore wins.
  function automatic logic [PTR_W:0] find_en(input int start,
                                             input logic [CHANNELS-1:0] en);
    logic [PTR_W:0] r;
    int j;
    r = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      j = (start + i) % CHANNELS;
      if (en[j]) r = {1'b1, PTR_W'(j)};
    end
    return r;
  endfunction

  // A MANUAL select is good only if it names an existing, enabled channel.
  always_comb begin
    sel_ok = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if ((int'(sel_in) == k) && ch_en[k]) sel_ok = 1'b1;
    end
  end

  // Next-state and datapath logic.
  // Captures are decided by the current state, so a mode change only takes
  // effect from the following edge.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    dwell_d     = dwell_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    sel_err_d   = 1'b0;

    free     = !out_valid_q || out_ready;
    scan_hit = find_en(int'(ptr_q), ch_en);
    next_hit = find_en((int'(scan_hit[PTR_W-1:0]) + 1) % CHANNELS, ch_en);

    // An accepted sample leaves the slot; a capture below refills it.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      ST_MANUAL: begin
        if (free) begin
          out_valid_d = 1'b1;
          out_sel_d   = sel_in;
          if (sel_ok) begin
            out_data_d = pick(data_in, int'(sel_in));
          end else begin
            out_data_d = '0;
            sel_err_d  = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        // At the end of the dwell the counter and pointer freeze until the
        // slot is free, so no channel is skipped while the consumer stalls.
        if (dwell_q != DW_LAST) begin
          dwell_d = dwell_q + 1'b1;
        end else if (free && scan_hit[PTR_W]) begin
          out_valid_d = 1'b1;
          out_data_d  = pick(data_in, int'(scan_hit[PTR_W-1:0]));
          out_sel_d   = SEL_W'(scan_hit[PTR_W-1:0]);
          ptr_d       = next_hit[PTR_W-1:0];
          dwell_d     = '0;
        end
      end
      default: ;
    endcase

    if (!enable)   state_d = ST_IDLE;
    else if (mode) state_d = ST_SCAN;
    else           state_d = ST_MANUAL;

    // Outside SCAN the scan position is parked at zero.
    // As a result, every entry into SCAN restarts at channel 0 with a full dwell.
    if (state_d != ST_SCAN) begin
      ptr_d   = '0;
      dwell_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      dwell_q     <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      dwell_q     <= dwell_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

endmodule
